// File: rtl/video_pkg.sv
// Shared definitions for the programmable raster timing controller.
// VIDEO_TIMING_POL_EN adds the SYNC_POL field (address 8).
package video_pkg;

  localparam int CW = 12;
  localparam int TW = CW + 2;

  localparam logic [3:0] ADDR_H_ACTIVE = 4'd0;
  localparam logic [3:0] ADDR_H_FP     = 4'd1;
  localparam logic [3:0] ADDR_H_SYNC   = 4'd2;
  localparam logic [3:0] ADDR_H_BP     = 4'd3;
  localparam logic [3:0] ADDR_V_ACTIVE = 4'd4;
  localparam logic [3:0] ADDR_V_FP     = 4'd5;
  localparam logic [3:0] ADDR_V_SYNC   = 4'd6;
  localparam logic [3:0] ADDR_V_BP     = 4'd7;
  localparam logic [3:0] ADDR_SYNC_POL = 4'd8;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2
  } state_e;

  typedef struct packed {
    logic [CW-1:0] h_active;
    logic [CW-1:0] h_fp;
    logic [CW-1:0] h_sync;
    logic [CW-1:0] h_bp;
    logic [CW-1:0] v_active;
    logic [CW-1:0] v_fp;
    logic [CW-1:0] v_sync;
    logic [CW-1:0] v_bp;
    logic [1:0]    sync_pol;
  } timing_t;

  localparam timing_t TIMING_DEFAULT = '{
    h_active: CW'(640),
    h_fp:     CW'(16),
    h_sync:   CW'(96),
    h_bp:     CW'(48),
    v_active: CW'(480),
    v_fp:     CW'(10),
    v_sync:   CW'(2),
    v_bp:     CW'(33),
    sync_pol: 2'b00
  };

  // A zero-length region would make the counters misbehave, so 0 is stored as 1.
  function automatic logic [CW-1:0] field_val(input logic [CW-1:0] d);
    return (d == '0) ? CW'(1) : d;
  endfunction

endpackage

// File: rtl/video_timing_regs.sv
// Staging/shadow timing register sets with cfg handshake and frame-boundary commit.
// VIDEO_TIMING_POL_EN enables the SYNC_POL field.
module video_timing_regs
  import video_pkg::*;
(
  input  logic           i_clk,
  input  logic           i_rst_n,
  input  logic           i_cfg_valid,
  input  logic [3:0]     i_cfg_addr,
  input  logic [CW-1:0]  i_cfg_wdata,
  input  logic           i_cfg_commit,
  input  logic           i_idle,
  input  logic           i_start,
  input  logic           i_frame_end,
  output logic           o_cfg_ready,
  output logic           o_cfg_pending,
  output timing_t        o_shadow,
  output logic [TW-1:0]  o_h_tot,
  output logic [TW-1:0]  o_v_tot
);

  timing_t r_stage;
  timing_t r_shadow;
  logic    r_pending;
  logic    w_wr;
  logic    w_apply;

  assign w_wr    = i_cfg_valid & ~r_pending;
  // Shadow only moves when the counters are stopped or wrapping, so no frame is torn.
  assign w_apply = i_start | (i_idle & i_cfg_commit) |
                   (i_frame_end & (r_pending | i_cfg_commit));

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_stage <= TIMING_DEFAULT;
    end else if (w_wr) begin
      case (i_cfg_addr)
        ADDR_H_ACTIVE: r_stage.h_active <= field_val(i_cfg_wdata);
        ADDR_H_FP:     r_stage.h_fp     <= field_val(i_cfg_wdata);
        ADDR_H_SYNC:   r_stage.h_sync   <= field_val(i_cfg_wdata);
        ADDR_H_BP:     r_stage.h_bp     <= field_val(i_cfg_wdata);
        ADDR_V_ACTIVE: r_stage.v_active <= field_val(i_cfg_wdata);
        ADDR_V_FP:     r_stage.v_fp     <= field_val(i_cfg_wdata);
        ADDR_V_SYNC:   r_stage.v_sync   <= field_val(i_cfg_wdata);
        ADDR_V_BP:     r_stage.v_bp     <= field_val(i_cfg_wdata);
`ifdef VIDEO_TIMING_POL_EN
        ADDR_SYNC_POL: r_stage.sync_pol <= i_cfg_wdata[1:0];
`endif
        default: ;
      endcase
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_shadow  <= TIMING_DEFAULT;
      r_pending <= 1'b0;
    end else begin
      if (w_apply) begin
        r_shadow <= r_stage;
      end
      if (w_apply) begin
        r_pending <= 1'b0;
      end else if (i_cfg_commit && !i_idle) begin
        r_pending <= 1'b1;
      end
    end
  end

  assign o_cfg_ready   = ~r_pending;
  assign o_cfg_pending = r_pending;
  assign o_shadow      = r_shadow;
  assign o_h_tot = TW'(r_shadow.h_active) + TW'(r_shadow.h_fp) +
                   TW'(r_shadow.h_sync) + TW'(r_shadow.h_bp);
  assign o_v_tot = TW'(r_shadow.v_active) + TW'(r_shadow.v_fp) +
                   TW'(r_shadow.v_sync) + TW'(r_shadow.v_bp);

endmodule

// File: rtl/video_timing_ctrl.sv
// Programmable raster timing controller: run/drain FSM, h/v counters, registered sync outputs.
// VIDEO_TIMING_POL_EN enables programmable sync polarity (handled in video_timing_regs).
module video_timing_ctrl
  import video_pkg::*;
(
  input  logic           i_clk,
  input  logic           i_rst_n,
  input  logic           i_enable,
  input  logic           i_cfg_valid,
  output logic           o_cfg_ready,
  input  logic [3:0]     i_cfg_addr,
  input  logic [CW-1:0]  i_cfg_wdata,
  input  logic           i_cfg_commit,
  output logic           o_cfg_pending,
  output logic           o_running,
  output logic           o_blank,
  output logic           o_hsync,
  output logic           o_vsync,
  output logic [CW-1:0]  o_x,
  output logic [CW-1:0]  o_y,
  output logic           o_frame_start
);

  state_e        r_state;
  state_e        w_state_next;
  logic [CW-1:0] r_hcnt;
  logic [CW-1:0] r_vcnt;
  timing_t       w_shadow;
  logic [TW-1:0] w_h_tot;
  logic [TW-1:0] w_v_tot;
  logic          w_active;
  logic          w_start;
  logic          w_line_end;
  logic          w_last_line;
  logic          w_frame_end;
  logic [TW-1:0] w_h_ext;
  logic [TW-1:0] w_v_ext;
  logic [TW-1:0] w_hs_beg;
  logic [TW-1:0] w_hs_end;
  logic [TW-1:0] w_vs_beg;
  logic [TW-1:0] w_vs_end;
  logic          w_blank;
  logic          w_hsync;
  logic          w_vsync;
  logic [CW-1:0] w_x;
  logic [CW-1:0] w_y;
  logic          w_frame_start;

  video_timing_regs u_regs (
    .i_clk         (i_clk),
    .i_rst_n       (i_rst_n),
    .i_cfg_valid   (i_cfg_valid),
    .i_cfg_addr    (i_cfg_addr),
    .i_cfg_wdata   (i_cfg_wdata),
    .i_cfg_commit  (i_cfg_commit),
    .i_idle        (~w_active),
    .i_start       (w_start),
    .i_frame_end   (w_frame_end),
    .o_cfg_ready   (o_cfg_ready),
    .o_cfg_pending (o_cfg_pending),
    .o_shadow      (w_shadow),
    .o_h_tot       (w_h_tot),
    .o_v_tot       (w_v_tot)
  );

  assign w_active    = (r_state != ST_IDLE);
  assign w_start     = (r_state == ST_IDLE) & i_enable;
  assign w_h_ext     = {2'b00, r_hcnt};
  assign w_v_ext     = {2'b00, r_vcnt};
  assign w_line_end  = (w_h_ext == w_h_tot - TW'(1));
  assign w_last_line = (w_v_ext == w_v_tot - TW'(1));
  assign w_frame_end = w_active & w_line_end & w_last_line;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Dropping enable always lets the current frame finish; a stop requested in RUN
  // that lands on the last pixel goes straight to IDLE.
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      ST_IDLE:  if (i_enable) w_state_next = ST_RUN;
      ST_RUN,
      ST_DRAIN: begin
        if (w_frame_end) w_state_next = i_enable ? ST_RUN : ST_IDLE;
        else             w_state_next = i_enable ? ST_RUN : ST_DRAIN;
      end
      default:  w_state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_hcnt <= '0;
      r_vcnt <= '0;
    end else if (!w_active) begin
      r_hcnt <= '0;
      r_vcnt <= '0;
    end else if (w_line_end) begin
      r_hcnt <= '0;
      r_vcnt <= w_last_line ? '0 : r_vcnt + CW'(1);
    end else begin
      r_hcnt <= r_hcnt + CW'(1);
    end
  end

  assign w_hs_beg = TW'(w_shadow.h_active) + TW'(w_shadow.h_fp);
  assign w_hs_end = w_hs_beg + TW'(w_shadow.h_sync);
  assign w_vs_beg = TW'(w_shadow.v_active) + TW'(w_shadow.v_fp);
  assign w_vs_end = w_vs_beg + TW'(w_shadow.v_sync);

  always_comb begin
    w_blank       = 1'b1;
    w_hsync       = w_shadow.sync_pol[0];
    w_vsync       = w_shadow.sync_pol[1];
    w_x           = '0;
    w_y           = '0;
    w_frame_start = 1'b0;
    if (w_active) begin
      w_blank       = (r_hcnt >= w_shadow.h_active) | (r_vcnt >= w_shadow.v_active);
      w_hsync       = ((w_h_ext >= w_hs_beg) & (w_h_ext < w_hs_end)) ^ w_shadow.sync_pol[0];
      w_vsync       = ((w_v_ext >= w_vs_beg) & (w_v_ext < w_vs_end)) ^ w_shadow.sync_pol[1];
      w_x           = r_hcnt;
      w_y           = r_vcnt;
      w_frame_start = (r_hcnt == '0) & (r_vcnt == '0);
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      o_blank       <= 1'b1;
      o_hsync       <= 1'b0;
      o_vsync       <= 1'b0;
      o_x           <= '0;
      o_y           <= '0;
      o_frame_start <= 1'b0;
    end else begin
      o_blank       <= w_blank;
      o_hsync       <= w_hsync;
      o_vsync       <= w_vsync;
      o_x           <= w_x;
      o_y           <= w_y;
      o_frame_start <= w_frame_start;
    end
  end

  assign o_running = w_active;

endmodule

// File: tb/tb_video_timing_ctrl.sv
// Self-checking bench for video_timing_ctrl: vector table, directed corner cases, random run vs pixel-position model.
module tb_video_timing_ctrl;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        en = 1'b0;
  logic        cfg_valid = 1'b0;
  logic        cfg_ready;
  logic [3:0]  cfg_addr = 4'd0;
  logic [11:0] cfg_wdata = 12'd0;
  logic        cfg_commit = 1'b0;
  logic        cfg_pending;
  logic        running;
  logic        blank;
  logic        hsync;
  logic        vsync;
  logic [11:0] x;
  logic [11:0] y;
  logic        frame_start;

  video_timing_ctrl dut (
    .i_clk         (clk),
    .i_rst_n       (rst_n),
    .i_enable      (en),
    .i_cfg_valid   (cfg_valid),
    .o_cfg_ready   (cfg_ready),
    .i_cfg_addr    (cfg_addr),
    .i_cfg_wdata   (cfg_wdata),
    .i_cfg_commit  (cfg_commit),
    .o_cfg_pending (cfg_pending),
    .o_running     (running),
    .o_blank       (blank),
    .o_hsync       (hsync),
    .o_vsync       (vsync),
    .o_x           (x),
    .o_y           (y),
    .o_frame_start (frame_start)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_miss = 0;
  int cyc = 0;
  int last_fs = -1;
  int fs_period = 0;

  // Model: timing fields as integers, frame position as a linear pixel index.
  int stg[9];
  int shd[9];
  int m_pend, m_act, m_p;
  int e_blank, e_hs, e_vs, e_x, e_y, e_fs;

  typedef struct {
    logic en;
    logic commit;
    int   run;
    int   blank;
    int   fs;
    int   pend;
    int   x;
  } vec_t;
  vec_t tbl[6];

  task automatic chk(input string name, input int act, input int exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic int f_val(input int d);
    return (d == 0) ? 1 : d;
  endfunction

  task automatic model_reset();
    stg = '{640, 16, 96, 48, 480, 10, 2, 33, 0};
    shd = stg;
    m_pend = 0; m_act = 0; m_p = 0;
    e_blank = 1; e_hs = 0; e_vs = 0; e_x = 0; e_y = 0; e_fs = 0;
  endtask

  task automatic model_edge();
    int old[9];
    int ht, vt, h, v, pol;
    old = stg;
    pol = shd[8];
    ht = shd[0] + shd[1] + shd[2] + shd[3];
    vt = shd[4] + shd[5] + shd[6] + shd[7];
    if (m_act != 0) begin
      h = m_p % ht;
      v = m_p / ht;
      e_blank = int'((h >= shd[0]) || (v >= shd[4]));
      e_hs = int'((h >= shd[0] + shd[1]) && (h < shd[0] + shd[1] + shd[2])) ^ (pol & 1);
      e_vs = int'((v >= shd[4] + shd[5]) && (v < shd[4] + shd[5] + shd[6])) ^ ((pol >> 1) & 1);
      e_x = h; e_y = v; e_fs = int'(m_p == 0);
    end else begin
      e_blank = 1; e_hs = pol & 1; e_vs = (pol >> 1) & 1; e_x = 0; e_y = 0; e_fs = 0;
    end
    if (cfg_valid && m_pend == 0) begin
      if (cfg_addr < 4'd8) stg[cfg_addr] = f_val(int'(cfg_wdata));
`ifdef VIDEO_TIMING_POL_EN
      else if (cfg_addr == 4'd8) stg[8] = int'(cfg_wdata) & 3;
`endif
    end
    if (m_act == 0) begin
      if (en) begin
        shd = old; m_pend = 0; m_act = 1; m_p = 0;
      end else if (cfg_commit) begin
        shd = old;
      end
    end else if (m_p == ht * vt - 1) begin
      if (m_pend != 0 || cfg_commit) shd = old;
      m_pend = 0; m_p = 0;
      if (!en) m_act = 0;
    end else begin
      m_p++;
      if (cfg_commit) m_pend = 1;
    end
  endtask

  task automatic cycle();
    @(posedge clk);
    model_edge();
    #1;
    cyc++;
    chk("running", int'(running), m_act);
    chk("cfg_pending", int'(cfg_pending), m_pend);
    chk("cfg_ready", int'(cfg_ready), 1 - m_pend);
    chk("blank", int'(blank), e_blank);
    chk("hsync", int'(hsync), e_hs);
    chk("vsync", int'(vsync), e_vs);
    chk("frame_start", int'(frame_start), e_fs);
    if (e_blank == 0) begin
      chk("x", int'(x), e_x);
      chk("y", int'(y), e_y);
    end
    if (frame_start) begin
      if (last_fs >= 0) fs_period = cyc - last_fs;
      last_fs = cyc;
    end
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) cycle();
  endtask

  task automatic write_cfg(input int a, input int d);
    cfg_valid = 1'b1; cfg_addr = 4'(a); cfg_wdata = 12'(d);
    cycle();
    cfg_valid = 1'b0;
  endtask

  task automatic commit_pulse();
    cfg_commit = 1'b1;
    cycle();
    cfg_commit = 1'b0;
  endtask

  task automatic wait_idle(input int bound);
    for (int i = 0; i < bound; i++) begin
      if (!running) break;
      cycle();
    end
    chk("drain_to_idle", int'(running), 0);
  endtask

  task automatic async_reset();
    #2 rst_n = 1'b0;
    #1;
    model_reset();
    chk("rst_running", int'(running), 0);
    chk("rst_blank", int'(blank), 1);
    chk("rst_hsync", int'(hsync), 0);
    chk("rst_vsync", int'(vsync), 0);
    chk("rst_fs", int'(frame_start), 0);
    chk("rst_pending", int'(cfg_pending), 0);
    en = 1'b0; cfg_valid = 1'b0; cfg_commit = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    last_fs = -1;
  endtask

  task automatic default_line_check();
    int cnt, first;
    cnt = 0; first = -1;
    for (int i = 0; i < 800; i++) begin
      cycle();
      if (hsync) begin
        cnt++;
        if (first < 0) first = int'(x);
      end
    end
    chk("hsync_width_default", cnt, 96);
    chk("hsync_start_default", first, 656);
  endtask

  initial begin
    int drops, vcount, r;
    model_reset();
    tbl[0] = '{1'b0, 1'b0, 0, 1, 0, 0, 0};
    tbl[1] = '{1'b1, 1'b0, 1, 1, 0, 0, 0};
    tbl[2] = '{1'b1, 1'b0, 1, 0, 1, 0, 0};
    tbl[3] = '{1'b1, 1'b0, 1, 0, 0, 0, 1};
    tbl[4] = '{1'b1, 1'b1, 1, 0, 0, 1, 2};
    tbl[5] = '{1'b1, 1'b0, 1, 0, 0, 1, 3};
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 6; i++) begin
      en = tbl[i].en; cfg_commit = tbl[i].commit;
      cycle();
      chk("tbl_running", int'(running), tbl[i].run);
      chk("tbl_blank", int'(blank), tbl[i].blank);
      chk("tbl_frame_start", int'(frame_start), tbl[i].fs);
      chk("tbl_pending", int'(cfg_pending), tbl[i].pend);
      if (tbl[i].blank == 0) chk("tbl_x", int'(x), tbl[i].x);
    end
    cfg_commit = 1'b0;
    default_line_check();
    // Write while pending must be stalled.
    write_cfg(0, 5);
    async_reset();

    // Small raster 15x10 programmed in IDLE.
    write_cfg(0, 8); write_cfg(1, 2); write_cfg(2, 3); write_cfg(3, 2);
    write_cfg(4, 6); write_cfg(5, 1); write_cfg(6, 2); write_cfg(7, 1);
    write_cfg(15, 9);
    commit_pulse();
    chk("idle_commit_no_pending", int'(cfg_pending), 0);
    en = 1'b1;
    run(320);
    chk("period_small", fs_period, 150);

    // Mid-frame H_ACTIVE change applies only at the frame boundary.
    write_cfg(0, 4);
    commit_pulse();
    chk("pending_mid", int'(cfg_pending), 1);
    chk("ready_mid", int'(cfg_ready), 0);
    for (int i = 0; i < 200; i++) begin
      if (!cfg_pending) break;
      cycle();
    end
    chk("pending_cleared", int'(cfg_pending), 0);
    chk("period_old_frame", fs_period, 150);
    run(230);
    chk("period_new_frame", fs_period, 110);

    // Drain to IDLE, then a drain interrupted by enable.
    en = 1'b0;
    wait_idle(200);
    en = 1'b1;
    run(30);
    en = 1'b0;
    drops = 0;
    for (int i = 0; i < 20; i++) begin cycle(); if (!running) drops++; end
    en = 1'b1;
    for (int i = 0; i < 200; i++) begin cycle(); if (!running) drops++; end
    chk("drain_no_interrupt", drops, 0);
    chk("period_after_drain", fs_period, 110);

    // V_SYNC written as 0 becomes a one-line pulse.
    en = 1'b0;
    wait_idle(200);
    write_cfg(6, 0);
    commit_pulse();
`ifdef VIDEO_TIMING_POL_EN
    write_cfg(8, 3);
    commit_pulse();
    chk("pol_idle_hsync", int'(hsync), 1);
    chk("pol_idle_vsync", int'(vsync), 1);
`endif
    en = 1'b1;
    for (int i = 0; i < 20; i++) begin
      if (frame_start) break;
      cycle();
    end
    chk("frame_start_seen", int'(frame_start), 1);
    vcount = 0;
    for (int i = 0; i < 110; i++) begin
`ifdef VIDEO_TIMING_POL_EN
      if (!vsync) vcount++;
`else
      if (vsync) vcount++;
`endif
      cycle();
    end
    chk("vsync_one_line", vcount, 11);

    // Random traffic with small field values.
    for (int i = 0; i < 20000; i++) begin
      cfg_valid = ($urandom_range(0, 3) == 0);
      r = int'($urandom_range(0, 10));
      cfg_addr = (r == 10) ? 4'd15 : 4'(r);
      cfg_wdata = 12'($urandom_range(0, 6));
      cfg_commit = ($urandom_range(0, 49) == 0);
      if ($urandom_range(0, 299) == 0) en = ~en;
      cycle();
    end
    cfg_valid = 1'b0; cfg_commit = 1'b0;

    // Reset while running restores the defaults.
    en = 1'b1;
    run(37);
    async_reset();
    en = 1'b1;
    default_line_check();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
